arith_unit_mc: RTL

//  Next-generation arithmetic unit: parametrised width, valid/ready handshake on both sides,

---
 rtl/alu_pkg.sv | 20 ++
 rtl/arith_seq_div.sv | 64 ++++++
 rtl/arith_unit_mc.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the arithmetic unit: operation codes, FSM states
// and the packed status-flag payload that travels with each result.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic carry;
    logic zero;
    logic div_zero;
  } flags_t;

endpackage

// File: rtl/arith_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first iteration is taken on the start edge itself, so done rises
// WIDTH-1 cycles after start and the quotient/remainder are then final.
// Only instantiated when ARITH_UNIT_DIV_EN is defined.
// Ports:
//   clk, rst            clock, async active-low reset
//   start               load operands and perform the first iteration
//   dividend, divisor   operands, sampled on start
//   done                all WIDTH iterations complete
//   quotient, remainder results, valid while done
module arith_seq_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   trial;
  logic             step;

  // On start the iteration operates on the fresh operands instead of the registers.
  assign src_rem = start ? '0       : rem;
  assign src_quo = start ? dividend : quo;
  assign src_dvs = start ? divisor  : dvs;
  assign trial   = {src_rem, src_quo[WIDTH-1]} - {1'b0, src_dvs};
  assign step    = start | (running & (cnt != LAST));

  // Partial remainder / shifting quotient register and iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      running <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (step) begin
      cnt     <= start ? CW'(1) : cnt + CW'(1);
      running <= 1'b1;
      dvs     <= src_dvs;
      // trial MSB set means the subtraction went negative: restore.
      if (!trial[WIDTH]) rem <= trial[WIDTH-1:0];
      else               rem <= {src_rem[WIDTH-2:0], src_quo[WIDTH-1]};
      quo <= {src_quo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  assign done      = running & (cnt == LAST);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/arith_unit_mc.sv
// Arithmetic unit with valid/ready handshake: single-cycle ADD/SUB/MUL and
// an iterative unsigned DIV that back-pressures upstream while it runs.
// Build option: define ARITH_UNIT_DIV_EN to include the divider; without it
// op=DIV completes in one cycle with result 0 and div_zero flagging an
// unsupported operation, and busy is tied low.
// Ports:
//   clk, rst           clock, async active-low reset
//   in_valid/in_ready  upstream handshake (in_ready combinational)
//   op, a, b           operation and operands, captured at accept
//   out_valid/out_ready downstream handshake
//   result             2*WIDTH result ({remainder, quotient} for DIV)
//   carry, zero, div_zero  status flags held with result
//   busy               divider iterating
module arith_unit_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               div_zero,
  output logic               busy
);

  localparam int unsigned RW = 2 * WIDTH;

  logic [1:0]    state, state_next;
  logic          rst_done;
  logic          accept;
  logic          out_valid_next;
  logic [RW-1:0] res_calc, res_next;
  flags_t        flags_calc, flags_q, flags_next;
  logic          go_div;
  logic [WIDTH:0] sum, diff;
  logic [RW-1:0] prod;

`ifdef ARITH_UNIT_DIV_EN
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q, div_r;

  arith_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign busy = (state == ST_DIV);
`else
  assign busy = 1'b0;
`endif

  // rst_done keeps in_ready low until the first edge after reset release.
  assign in_ready = rst_done & (state != ST_DIV) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = RW'(a) * RW'(b);

  // Single-cycle result and flags for the operation being offered.
  always_comb begin
    res_calc   = '0;
    flags_calc = '0;
    go_div     = 1'b0;
    case (op)
      OP_ADD: begin
        res_calc         = RW'(sum[WIDTH-1:0]);
        flags_calc.carry = sum[WIDTH];
      end
      OP_SUB: begin
        res_calc         = RW'(diff[WIDTH-1:0]);
        flags_calc.carry = diff[WIDTH];
      end
      OP_MUL: res_calc = prod;
      default: begin
`ifdef ARITH_UNIT_DIV_EN
        if (b == '0) begin
          res_calc            = {a, {WIDTH{1'b1}}};
          flags_calc.div_zero = 1'b1;
        end else begin
          go_div = 1'b1;
        end
`else
        flags_calc.div_zero = 1'b1;
`endif
      end
    endcase
    flags_calc.zero = (res_calc == '0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid;
    res_next       = result;
    flags_next     = flags_q;
`ifdef ARITH_UNIT_DIV_EN
    div_start      = 1'b0;
`endif
    if (out_valid && out_ready) begin
      out_valid_next = 1'b0;
      state_next     = ST_IDLE;
    end
    case (state)
      ST_DIV: begin
`ifdef ARITH_UNIT_DIV_EN
        if (div_done) begin
          state_next      = ST_RESP;
          out_valid_next  = 1'b1;
          res_next        = {div_r, div_q};
          flags_next      = '0;
          flags_next.zero = ({div_r, div_q} == '0);
        end
`endif
      end
      default: begin
        // RESP accepts too when the held result drains this cycle.
        if (accept) begin
          if (go_div) begin
            state_next = ST_DIV;
`ifdef ARITH_UNIT_DIV_EN
            div_start  = 1'b1;
`endif
          end else begin
            state_next     = ST_RESP;
            out_valid_next = 1'b1;
            res_next       = res_calc;
            flags_next     = flags_calc;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else begin
      state     <= state_next;
      rst_done  <= 1'b1;
      out_valid <= out_valid_next;
      result    <= res_next;
      flags_q   <= flags_next;
    end
  end

  assign carry    = flags_q.carry;
  assign zero     = flags_q.zero;
  assign div_zero = flags_q.div_zero;

endmodule
